lector_rtc: RTL and testbench
=============================

# lector_rtc

Upstream bus master for the RTC display path. On each start pulse it runs a burst of multiplexed address/data read cycles on the external RTC bus and presents each returned byte to the display interface stage as `datoRTC` with a one-cycle valid strobe and an index. The burst covers 9 clock registers, or 13 when the timer is active. The display stage stores each byte by index and converts it to ASCII while the screen refreshes.

## Interface
- `T_PULSE`, 10: cycles that `cs_n` and `rd_n`/`wr_n` stay asserted per phase (100 ns at 100 MHz); must be ≥ 2.
- `T_GAP`, 5: cycles with all strobes deasserted after each phase; must be ≥ 1.
- `clk` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `inicio` in 1: start pulse (frame-refresh tick); one burst per accepted pulse.
- `temporizador` in 1: timer active; sampled only when `inicio` is accepted.
- `ad_in` in 8: RTC bus input (pad input side).
- `ad_out` out 8: RTC bus output (address or write data).
- `ad_oe` out 1: pad output enable for `ad_out`.
- `cs_n`, `rd_n`, `wr_n` out 1 each: active-low chip select, read strobe and write strobe.
- `a_d` out 1: 0 = address phase, 1 = data phase.
- `datoRTC` out 8: last byte read; held until the next read.
- `dato_valido` out 1: one-cycle strobe; `datoRTC` and `indice` are valid in that cycle.
- `indice` out 4: register index of `datoRTC`.
- `ocupado` out 1: burst in progress.
- `fin` out 1: one-cycle pulse when the burst completes.

## Operation
- Index-to-address map:
  - 0..8 → 0x20..0x28: centesimas, segundos, minutos, horas, fecha, mes, año, diaSemana, numeroSemana.
  - 9..12 → 0x40..0x43: centesimasT, segundosT, minutosT, horasT.
- Burst length N = 13 if `temporizador` was 1 at start, else 9.
- FSM states: IDLE, DIR, ESP_D, DATO, ESP_F, SIG; with the macro also TR_DIR, TR_ESP_D, TR_DATO, TR_ESP_F.
- One phase counter of width clog2(max(T_PULSE,T_GAP))+1; it reloads on every state change.
- IDLE: when `inicio`=1, go to DIR (or TR_DIR), set `ocupado`=1, set `indice`=0, latch N.
- DIR, T_PULSE cycles:
  - `a_d`=0, `cs_n`=0, `wr_n`=0, `ad_oe`=1, `ad_out`=address(indice).
- ESP_D, T_GAP cycles: strobes high; `ad_oe` stays 1 (address hold).
- DATO, T_PULSE cycles:
  - `a_d`=1, `cs_n`=0, `rd_n`=0, `ad_oe`=0.
  - `ad_in` is captured into `datoRTC` on the last cycle of DATO.
- ESP_F, T_GAP cycles: strobes high, `ad_oe`=0.
  - `dato_valido` pulses in the first cycle of ESP_F.
- SIG, 1 cycle:
  - if `indice`=N-1: go to IDLE, `ocupado`=0, `fin`=1 for 1 cycle.
  - otherwise: `indice`+1, go to DIR.
- `rd_n` and `wr_n` are never low in the same cycle. `ad_oe` is never 1 while `rd_n`=0.
- `inicio` while `ocupado`=1 is ignored (it is not queued).
- A change of `temporizador` mid-burst has no effect until the next burst.
- `inicio` in the same cycle as `reset`: reset wins.

## Timing
- Reset value of every output:
  - `cs_n`=`rd_n`=`wr_n`=`a_d`=1.
  - `ad_oe`=0, `ad_out`=0x00.
  - `datoRTC`=0x00, `dato_valido`=0, `indice`=0, `ocupado`=0, `fin`=0.
- `ocupado` rises the cycle after `inicio` is sampled.
- One read = 2·T_PULSE + 2·T_GAP + 1 cycles (31 at defaults).
- Burst = N·31 cycles: 279 for 9 reads, 403 for 13 reads; add 31 with the macro.
- `fin` is asserted in the same cycle that `ocupado` falls.
- A new `inicio` is accepted in the cycle after `fin`.
- Reset mid-burst: all outputs return to reset values at the next edge; no partial strobe is extended.

## Configuration
- `RTC_TRANSFER_EN` defined:
  - each burst begins with a write: TR_DIR puts address 0xF0 on the bus, then TR_DATO drives data 0xF0 (`a_d`=1, `wr_n`=0, `ad_oe`=1), then TR_ESP_F.
  - This latches the RTC user registers before reading.
  - No `dato_valido` is produced for this write; `indice` stays 0.
- Macro undefined: TR_* states are absent; bursts start directly at DIR.

## Test plan
- Reset then idle 50 cycles → all outputs at reset values and bus idle (`cs_n`=1, `ad_oe`=0).
- `temporizador`=0, `inicio` pulse, bus model returns 0x10+index → 9 `dato_valido` strobes with `indice` 0..8 and data 0x10..0x18; `fin` exactly 279 cycles after `ocupado` rises.
- `temporizador`=1 → 13 strobes; the index 9 read shows `ad_out`=0x40 in DIR; `fin` after 403 cycles.
- Second `inicio` at cycle 100 of a burst → ignored; exactly 9 strobes, one `fin`.
- `reset` asserted during DATO of index 4 → next cycle all strobes high, `ocupado`=0, no further `dato_valido`.
- With `RTC_TRANSFER_EN` → first bus cycle writes 0xF0/0xF0 with `wr_n` low; 9 strobes follow; burst takes 310 cycles.

Source files
------------

// File: rtl/lector_rtc.sv
// lector_rtc: bus master that reads the RTC clock registers in bursts of
// multiplexed address/data cycles and hands each byte to the display stage.
// Optional feature: define RTC_TRANSFER_EN to prefix every burst with a
// write of 0xF0 to address 0xF0, which latches the RTC user registers.
module lector_rtc #(
    parameter int T_PULSE = 10,
    parameter int T_GAP   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio,
    input  logic       temporizador,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] datoRTC,
    output logic       dato_valido,
    output logic [3:0] indice,
    output logic       ocupado,
    output logic       fin
);

    localparam int CNT_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] PULSE_LAST = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(T_GAP - 1);
    localparam logic [CW-1:0] GAP_SLOT   = CW'(T_GAP);

    typedef enum logic [3:0] {
        IDLE, DIR, ESP_D, DATO, ESP_F, SIG
`ifdef RTC_TRANSFER_EN
        , TR_DIR, TR_ESP_D, TR_DATO, TR_ESP_F
`endif
    } state_t;

`ifdef RTC_TRANSFER_EN
    localparam state_t FIRST = TR_DIR;
`else
    localparam state_t FIRST = DIR;
`endif

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     indice_q, indice_d;
    logic [3:0]     last_q, last_d;
    logic           ocupado_q, ocupado_d;
    logic           fin_q, fin_d;
    logic           valido_q, valido_d;
    logic [7:0]     dato_q, dato_d;
    logic [7:0]     ad_out_q, ad_out_d;
    logic           ad_oe_q, ad_oe_d;
    logic           cs_n_q, cs_n_d;
    logic           rd_n_q, rd_n_d;
    logic           wr_n_q, wr_n_d;
    logic           a_d_q, a_d_d;

    // Clock registers live at 0x20..0x28, timer registers at 0x40..0x43.
    function automatic logic [7:0] direccion(input logic [3:0] i);
        if (i < 4'd9) return 8'h20 + {4'h0, i};
        else          return 8'h40 + {4'h0, i} - 8'd9;
    endfunction

    // State, phase counter and bus outputs register; bus strobes are
    // registered from the next-state decode so the pads never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            indice_q  <= 4'd0;
            last_q    <= 4'd8;
            ocupado_q <= 1'b0;
            fin_q     <= 1'b0;
            valido_q  <= 1'b0;
            dato_q    <= 8'h00;
            ad_out_q  <= 8'h00;
            ad_oe_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            a_d_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            indice_q  <= indice_d;
            last_q    <= last_d;
            ocupado_q <= ocupado_d;
            fin_q     <= fin_d;
            valido_q  <= valido_d;
            dato_q    <= dato_d;
            ad_out_q  <= ad_out_d;
            ad_oe_q   <= ad_oe_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            a_d_q     <= a_d_d;
        end
    end

    // Next-state sequencing and bus decode of the state being entered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        indice_d  = indice_q;
        last_d    = last_q;
        ocupado_d = ocupado_q;
        fin_d     = 1'b0;
        valido_d  = 1'b0;
        dato_d    = dato_q;

        case (state_q)
            IDLE: begin
                // The fin cycle itself does not accept a start: a new burst
                // begins no earlier than the cycle after fin.
                if (inicio && !fin_q) begin
                    state_d   = FIRST;
                    ocupado_d = 1'b1;
                    indice_d  = 4'd0;
                    last_d    = temporizador ? 4'd12 : 4'd8;
                end
            end
            DIR:   if (cnt_q == PULSE_LAST) state_d = ESP_D;
            ESP_D: if (cnt_q == GAP_LAST)   state_d = DATO;
            DATO: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d  = ESP_F;
                    dato_d   = ad_in;
                    valido_d = 1'b1;
                end
            end
            ESP_F: if (cnt_q == GAP_LAST) state_d = SIG;
            SIG: begin
                if (indice_q == last_q) begin
                    state_d   = IDLE;
                    ocupado_d = 1'b0;
                    fin_d     = 1'b1;
                end else begin
                    indice_d = indice_q + 4'd1;
                    state_d  = DIR;
                end
            end
`ifdef RTC_TRANSFER_EN
            TR_DIR:   if (cnt_q == PULSE_LAST) state_d = TR_ESP_D;
            TR_ESP_D: if (cnt_q == GAP_LAST)   state_d = TR_DATO;
            TR_DATO:  if (cnt_q == PULSE_LAST) state_d = TR_ESP_F;
            // One extra slot, like SIG, so the write takes a full read slot.
            TR_ESP_F: if (cnt_q == GAP_SLOT)   state_d = DIR;
`endif
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
        if (state_d == IDLE)    cnt_d = '0;

        ad_out_d = 8'h00;
        ad_oe_d  = 1'b0;
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        a_d_d    = 1'b1;
        case (state_d)
            DIR: begin
                a_d_d = 1'b0; cs_n_d = 1'b0; wr_n_d = 1'b0;
                ad_oe_d = 1'b1; ad_out_d = direccion(indice_d);
            end
            ESP_D: begin
                a_d_d = 1'b0; ad_oe_d = 1'b1; ad_out_d = direccion(indice_d);
            end
            DATO: begin
                cs_n_d = 1'b0; rd_n_d = 1'b0;
            end
`ifdef RTC_TRANSFER_EN
            TR_DIR: begin
                a_d_d = 1'b0; cs_n_d = 1'b0; wr_n_d = 1'b0;
                ad_oe_d = 1'b1; ad_out_d = 8'hF0;
            end
            TR_ESP_D: begin
                a_d_d = 1'b0; ad_oe_d = 1'b1; ad_out_d = 8'hF0;
            end
            TR_DATO: begin
                cs_n_d = 1'b0; wr_n_d = 1'b0; ad_oe_d = 1'b1; ad_out_d = 8'hF0;
            end
`endif
            default: ;
        endcase
    end

    assign ad_out      = ad_out_q;
    assign ad_oe       = ad_oe_q;
    assign cs_n        = cs_n_q;
    assign rd_n        = rd_n_q;
    assign wr_n        = wr_n_q;
    assign a_d         = a_d_q;
    assign datoRTC     = dato_q;
    assign dato_valido = valido_q;
    assign indice      = indice_q;
    assign ocupado     = ocupado_q;
    assign fin         = fin_q;

endmodule

// File: tb/tb_lector_rtc.sv
// Testbench for lector_rtc: RTC bus model with random register contents,
// reference stream derived from the register map and burst timing rules.
module tb_lector_rtc;

    localparam int TP       = 10;
    localparam int TG       = 5;
    localparam int READ_CYC = 2 * TP + 2 * TG + 1;
`ifdef RTC_TRANSFER_EN
    localparam int EXTRA    = READ_CYC;
`else
    localparam int EXTRA    = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inicio = 1'b0;
    logic       temporizador = 1'b0;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe, cs_n, rd_n, wr_n, a_d;
    logic [7:0] datoRTC;
    logic       dato_valido;
    logic [3:0] indice;
    logic       ocupado, fin;

    lector_rtc #(.T_PULSE(TP), .T_GAP(TG)) dut (
        .clk(clk), .reset(reset), .inicio(inicio), .temporizador(temporizador),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n),
        .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d), .datoRTC(datoRTC),
        .dato_valido(dato_valido), .indice(indice), .ocupado(ocupado), .fin(fin)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Register map: index -> bus address.
    logic [7:0] ADDR_TAB [13] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                  8'h27, 8'h28, 8'h40, 8'h41, 8'h42, 8'h43};

    // RTC bus model: latch the address phase, return the stored byte.
    logic [7:0] mem [256];
    logic [7:0] bus_addr = 8'h00;
    assign ad_in = mem[bus_addr];
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (!cs_n && !a_d && ad_oe) bus_addr <= ad_out;

    // Observation state filled by the monitor.
    logic [3:0] got_idx [$];
    logic [7:0] got_dat [$];
    logic [7:0] addr_seen [16];
    logic [7:0] first_addr;
    bit         first_pend = 1'b1;
    logic [7:0] wr_data = 8'h00;
    int         wr_cnt = 0;
    int         fin_cnt = 0;
    int         rise_cyc = 0;
    int         fin_cyc = 0;
    logic       ocup_prev = 1'b0;

    always @(negedge clk) begin
        if (dato_valido) begin
            got_idx.push_back(indice);
            got_dat.push_back(datoRTC);
        end
        if (!cs_n && !wr_n && !a_d) begin
            addr_seen[indice] = ad_out;
            if (first_pend) begin
                first_addr = ad_out;
                first_pend = 1'b0;
            end
        end
        if (!cs_n && !wr_n && a_d) begin
            wr_data = ad_out;
            wr_cnt++;
        end
        if (ocupado && !ocup_prev) rise_cyc = cyc;
        if (fin) begin
            fin_cnt++;
            fin_cyc = cyc;
        end
        ocup_prev = ocupado;
        checks++;
        assert (!(!rd_n && !wr_n)) else begin
            errors++;
            $error("FAIL strobe_overlap: observed rd_n=%0b wr_n=%0b required not both 0", rd_n, wr_n);
        end
        checks++;
        assert (!(ad_oe && !rd_n)) else begin
            errors++;
            $error("FAIL oe_during_read: observed ad_oe=%0b rd_n=%0b required ad_oe=0", ad_oe, rd_n);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cs_n"}, 32'(cs_n), 32'd1);
        check({tag, "_rd_n"}, 32'(rd_n), 32'd1);
        check({tag, "_wr_n"}, 32'(wr_n), 32'd1);
        check({tag, "_a_d"}, 32'(a_d), 32'd1);
        check({tag, "_ad_oe"}, 32'(ad_oe), 32'd0);
        check({tag, "_ad_out"}, 32'(ad_out), 32'h0);
        check({tag, "_datoRTC"}, 32'(datoRTC), 32'h0);
        check({tag, "_valido"}, 32'(dato_valido), 32'd0);
        check({tag, "_indice"}, 32'(indice), 32'd0);
        check({tag, "_ocupado"}, 32'(ocupado), 32'd0);
        check({tag, "_fin"}, 32'(fin), 32'd0);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    // One burst: start pulse, optional second pulse at cycle inject_at,
    // optional temporizador flip mid-burst, then compare against the model.
    task automatic run_burst(input string tag, input bit tmr, input int inject_at,
                             input bit flip, input int post_idle);
        int n;
        int start;
        bit done;
        n = tmr ? 13 : 9;
        got_idx.delete();
        got_dat.delete();
        for (int i = 0; i < 16; i++) addr_seen[i] = 8'h00;
        first_pend = 1'b1;
        wr_cnt = 0;
        fin_cnt = 0;
        temporizador = tmr;
        inicio = 1'b1;
        start = cyc;
        @(posedge clk); #1;
        inicio = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (flip && (cyc - start) == 50) temporizador = ~tmr;
            inicio = (inject_at > 0 && (cyc - start) == inject_at);
            if (fin_cnt != 0) begin
                done = 1'b1;
                break;
            end
        end
        inicio = 1'b0;
        check({tag, "_fin_seen"}, 32'(done), 32'd1);
        check({tag, "_ocupado_rise"}, 32'(rise_cyc - start), 32'd1);
        check({tag, "_burst_len"}, 32'(fin_cyc - rise_cyc), 32'(n * READ_CYC + EXTRA));
        check({tag, "_strobes"}, 32'(got_idx.size()), 32'(n));
        for (int i = 0; i < n && i < got_idx.size(); i++) begin
            check($sformatf("%s_idx%0d", tag, i), 32'(got_idx[i]), 32'(i));
            check($sformatf("%s_dat%0d", tag, i), 32'(got_dat[i]), 32'(mem[ADDR_TAB[i]]));
            check($sformatf("%s_addr%0d", tag, i), 32'(addr_seen[i]), 32'(ADDR_TAB[i]));
        end
`ifdef RTC_TRANSFER_EN
        check({tag, "_first_addr"}, 32'(first_addr), 32'hF0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'hF0);
        check({tag, "_wr_cycles"}, 32'(wr_cnt), 32'(TP));
`else
        check({tag, "_first_addr"}, 32'(first_addr), 32'h20);
        check({tag, "_wr_cycles"}, 32'(wr_cnt), 32'd0);
`endif
        check({tag, "_ocupado_low"}, 32'(ocupado), 32'd0);
        repeat (post_idle) @(posedge clk);
        #1;
        if (post_idle > 0) begin
            check({tag, "_single_fin"}, 32'(fin_cnt), 32'd1);
            check({tag, "_no_requeue"}, 32'(ocupado), 32'd0);
            check({tag, "_strobes_after"}, 32'(got_idx.size()), 32'(n));
        end
    endtask

    initial begin
        bit found;
        fill_mem();
        for (int i = 0; i < 9; i++) mem[ADDR_TAB[i]] = 8'h10 + 8'(i);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check_reset_vals("idle50");

        run_burst("clk9", 1'b0, 0, 1'b0, 0);
        fill_mem();
        run_burst("tmr13", 1'b1, 0, 1'b0, 0);
        fill_mem();
        run_burst("inject", 1'b0, 100, 1'b0, 40);
        run_burst("flip_tmr", 1'b0, 0, 1'b1, 5);
        for (int r = 0; r < 4; r++) begin
            fill_mem();
            run_burst($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 0, 1'b0, $urandom_range(0, 3));
        end

        // Reset during the DATO phase of index 4.
        temporizador = 1'($urandom_range(0, 1));
        inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk); #1;
            if (indice == 4'd4 && !rd_n) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_mid_reach_dato4", 32'(found), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_vals("rst_mid");
        got_idx.delete();
        repeat (60) @(posedge clk);
        #1;
        check("rst_mid_no_valid", 32'(got_idx.size()), 32'd0);
        check("rst_mid_idle", 32'(ocupado), 32'd0);

        // Start pulse coinciding with reset is dropped.
        reset = 1'b1;
        inicio = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        inicio = 1'b0;
        @(posedge clk); #1;
        check("rst_vs_inicio_ocupado", 32'(ocupado), 32'd0);
        check("rst_vs_inicio_cs_n", 32'(cs_n), 32'd1);

        fill_mem();
        run_burst("after_rst", 1'b1, 0, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
